mem_port_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-port synchronous RAM behind the processor datapath. It shares the RAM between the CPU memory port (MAR address, MDR write data, Read/Write strobes) and a debug/loader port used to preload programs and inspect memory. Each transaction follows a req/ack handshake, and ties are broken round-robin. The block drives RAM address, data and write-enable, captures read data, and returns it to the winning requester.

---
 rtl/mem_port_arbiter_pkg.sv | 48 ++++
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter_rr_arbiter_2.sv | 38 +++
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types and constants for the two-port RAM arbiter:
//               FSM state encoding, grant encoding, default bus widths and
//               the round-robin pick helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Defaults match the datapath's 32-bit bus and a 512-word RAM.
    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_READ_LAT   = 1;

    // Wide enough to hold the largest supported read latency (4).
    localparam int LAT_CNT_W = 3;

    // Grant encoding; last_grant uses the same encoding.
    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    // Two-way round-robin pick: a lone requester wins outright, a tie goes
    // to the port that did not win last time.
    function automatic logic rr_pick(input logic req_cpu,
                                     input logic req_dbg,
                                     input logic last_grant);
        logic pick;
        pick = last_grant;
        if (req_cpu && req_dbg) begin
            pick = ~last_grant;
        end else if (req_cpu) begin
            pick = GNT_CPU;
        end else if (req_dbg) begin
            pick = GNT_DBG;
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : One requester port of the RAM arbiter (req/ack handshake,
//               op select, address, write data, returned read data).
//               master = requester side, slave = arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = mem_port_arbiter_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = mem_port_arbiter_pkg::DEF_DATA_WIDTH
) ();

    logic                  req;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ack;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req,
        output wr,
        output addr,
        output wdata,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  wr,
        input  addr,
        input  wdata,
        output ack,
        output rdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_2
// Description : Two-requester round-robin arbiter. Produces the grant bit
//               combinationally and records it in last_grant whenever a
//               grant is taken while enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_2
    import mem_port_arbiter_pkg::*;
(
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic enable,
    input  wire logic req_cpu,
    input  wire logic req_dbg,
    output logic      valid,
    output logic      grant,
    output logic      last_grant
);

    logic r_last_grant;

    assign valid      = req_cpu | req_dbg;
    assign grant      = rr_pick(req_cpu, req_dbg, r_last_grant);
    assign last_grant = r_last_grant;

    // Remember the winner; reset to DBG so the CPU wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= GNT_DBG;
        end else if (enable && valid) begin
            r_last_grant <= grant;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one synchronous single-port RAM between the CPU
//               memory port and the debug/loader port. Sequences each
//               transaction through IDLE -> ISSUE -> (WAIT) -> ACK, drives
//               registered RAM address/data/write-enable and returns read
//               data to the granted port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int READ_LAT   = DEF_READ_LAT    // legal range 1..4
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    mem_port_arbiter_if.slave          cpu,
    mem_port_arbiter_if.slave          dbg,
    output logic [ADDR_WIDTH-1:0]      ram_addr,
    output logic [DATA_WIDTH-1:0]      ram_wdata,
    output logic                       ram_wren,
    input  wire logic [DATA_WIDTH-1:0] ram_q
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(READ_LAT);
    localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LAT_CNT_W-1:0]  r_lat_cnt;
    logic                  r_op_wr;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_dbg_rdata;
    logic                  w_cpu_ack;
    logic                  w_dbg_ack;
    logic                  w_arb_en;
    logic                  w_arb_valid;
    logic                  w_arb_grant;
    logic                  w_last_grant;
    logic                  w_grant_take;
    logic                  w_last_wait;

    // Requests are only looked at in IDLE; during a transaction last_grant
    // names the port being served.
    assign w_arb_en     = (r_state == IDLE);
    assign w_grant_take = w_arb_en && w_arb_valid;
    assign w_last_wait  = (r_state == WAIT) && (r_lat_cnt == LAT_LAST);

    rr_arbiter_2 u_arb (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (w_arb_en),
        .req_cpu    (cpu.req),
        .req_dbg    (dbg.req),
        .valid      (w_arb_valid),
        .grant      (w_arb_grant),
        .last_grant (w_last_grant)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and the single-cycle ack to the served port.
    always_comb begin
        w_state_nxt = r_state;
        w_cpu_ack   = 1'b0;
        w_dbg_ack   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = r_op_wr ? ACK : WAIT;
            end
            WAIT: begin
                if (r_lat_cnt == LAT_LAST) begin
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                w_state_nxt = IDLE;
                if (w_last_grant == GNT_CPU) begin
                    w_cpu_ack = 1'b1;
                end else begin
                    w_dbg_ack = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Latch the winner's command at grant; write-enable is high only for
    // the ISSUE cycle of a write, so it is set at grant and cleared after.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wren  <= 1'b0;
            r_op_wr   <= 1'b0;
        end else begin
            ram_wren <= 1'b0;
            if (w_grant_take) begin
                if (w_arb_grant == GNT_CPU) begin
                    ram_addr  <= cpu.addr;
                    ram_wdata <= cpu.wdata;
                    r_op_wr   <= cpu.wr;
                    ram_wren  <= cpu.wr;
                end else begin
                    ram_addr  <= dbg.addr;
                    ram_wdata <= dbg.wdata;
                    r_op_wr   <= dbg.wr;
                    ram_wren  <= dbg.wr;
                end
            end
        end
    end

    // Read latency counter: loaded in ISSUE of a read, counts down in WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lat_cnt <= '0;
        end else if ((r_state == ISSUE) && !r_op_wr) begin
            r_lat_cnt <= LAT_LOAD;
        end else if (r_state == WAIT) begin
            r_lat_cnt <= r_lat_cnt - LAT_LAST;
        end
    end

    // Capture RAM output into the served port's rdata on the last WAIT
    // cycle; the other port's rdata is left untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else if (w_last_wait) begin
            if (w_last_grant == GNT_CPU) begin
                r_cpu_rdata <= ram_q;
            end else begin
                r_dbg_rdata <= ram_q;
            end
        end
    end

    assign cpu.ack   = w_cpu_ack;
    assign dbg.ack   = w_dbg_ack;
    assign cpu.rdata = r_cpu_rdata;
    assign dbg.rdata = r_dbg_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter with READ_LAT=1 plus a
//               second instance with READ_LAT=3 for latency checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int DEPTH = 512;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cpu_if ();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dbg_if ();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cpu3_if ();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dbg3_if ();

    logic [AW-1:0] ram_addr1, ram_addr3;
    logic [DW-1:0] ram_wdata1, ram_wdata3, ram_q1, ram_q3;
    logic          ram_wren1, ram_wren3;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .cpu(cpu_if), .dbg(dbg_if),
        .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_wren(ram_wren1), .ram_q(ram_q1));

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .cpu(cpu3_if), .dbg(dbg3_if),
        .ram_addr(ram_addr3), .ram_wdata(ram_wdata3), .ram_wren(ram_wren3), .ram_q(ram_q3));

    // Synchronous RAM models: address registered at the edge, data out
    // READ_LAT edges later.
    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] mem3 [DEPTH];
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] pipe3 [3];

    always @(posedge clk) begin
        if (ram_wren1) mem1[ram_addr1] <= ram_wdata1;
        ram_q1 <= mem1[ram_addr1];
    end

    always @(posedge clk) begin
        if (ram_wren3) mem3[ram_addr3] <= ram_wdata3;
        pipe3[0] <= mem3[ram_addr3];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign ram_q3 = pipe3[2];

    function automatic logic [DW-1:0] init_word(input int a);
        return 32'h1000_0000 + 32'(a);
    endfunction

    // Scoreboard entry: which port acks, in which cycle, and both rdata values.
    typedef struct {
        logic          port;
        logic [DW-1:0] cpu_rd;
        logic [DW-1:0] dbg_rd;
        int            cyc;
    } exp_t;

    exp_t          sbq[$];
    exp_t          mon_e;
    logic [DW-1:0] model_cpu_rd = '0;
    logic [DW-1:0] model_dbg_rd = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic port, input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input int ack_cyc);
        exp_t e;
        if (wr) model_mem[addr] = wdata;
        else if (port == GNT_CPU) model_cpu_rd = model_mem[addr];
        else model_dbg_rd = model_mem[addr];
        e.port   = port;
        e.cpu_rd = model_cpu_rd;
        e.dbg_rd = model_dbg_rd;
        e.cyc    = ack_cyc;
        sbq.push_back(e);
    endtask

    // Monitor: every ack on the READ_LAT=1 instance is matched to the oldest
    // expected entry.
    always @(negedge clk) begin
        if (cpu_if.ack || dbg_if.ack) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: cpu_ack=%0b dbg_ack=%0b at cycle %0d, none expected",
                         cpu_if.ack, dbg_if.ack, cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("ack_port", {cpu_if.ack, dbg_if.ack}, (mon_e.port == GNT_CPU) ? 2'b10 : 2'b01);
                chk("ack_cycle", cyc, mon_e.cyc);
                chk("cpu_rdata", cpu_if.rdata, mon_e.cpu_rd);
                chk("dbg_rdata", dbg_if.rdata, mon_e.dbg_rd);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic port, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
        if (port == GNT_CPU) begin
            cpu_if.req = 1'b1; cpu_if.wr = wr; cpu_if.addr = addr; cpu_if.wdata = wdata;
        end else begin
            dbg_if.req = 1'b1; dbg_if.wr = wr; dbg_if.addr = addr; dbg_if.wdata = wdata;
        end
    endtask

    task automatic drop(input logic port);
        if (port == GNT_CPU) cpu_if.req = 1'b0;
        else dbg_if.req = 1'b0;
    endtask

    // Wait (bounded) for the port's ack; counts write-enable cycles seen.
    task automatic wait_ack(input logic port, output int wren_seen);
        bit got;
        got       = 1'b0;
        wren_seen = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (ram_wren1) wren_seen++;
            if ((port == GNT_CPU) ? cpu_if.ack : dbg_if.ack) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: port %0d got no ack within 40 cycles (cycle %0d)", port, cyc);
        end
    endtask

    // Single isolated transaction, issued from IDLE.
    task automatic txn(input logic port, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata);
        int w;
        push_exp(port, wr, addr, wdata, cyc + (wr ? 2 : 3));
        drive(port, wr, addr, wdata);
        wait_ack(port, w);
        chk(wr ? "write_wren_cycles" : "read_wren_cycles", w, wr ? 1 : 0);
        step();
        drop(port);
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        cpu_if.req  = 1'b0;
        dbg_if.req  = 1'b0;
        cpu3_if.req = 1'b0;
        dbg3_if.req = 1'b0;
        model_cpu_rd = '0;
        model_dbg_rd = '0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w1, w2, c;
        for (int i = 0; i < DEPTH; i++) begin
            mem1[i]      = init_word(i);
            mem3[i]      = init_word(i);
            model_mem[i] = init_word(i);
        end
        cpu_if.req  = 1'b0; cpu_if.wr  = 1'b0; cpu_if.addr  = '0; cpu_if.wdata  = '0;
        dbg_if.req  = 1'b0; dbg_if.wr  = 1'b0; dbg_if.addr  = '0; dbg_if.wdata  = '0;
        cpu3_if.req = 1'b0; cpu3_if.wr = 1'b0; cpu3_if.addr = '0; cpu3_if.wdata = '0;
        dbg3_if.req = 1'b0; dbg3_if.wr = 1'b0; dbg3_if.addr = '0; dbg3_if.wdata = '0;

        // Reset values with no requests
        step();
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_cpu_ack",    cpu_if.ack, 1'b0);
        chk("rst_dbg_ack",    dbg_if.ack, 1'b0);
        chk("rst_cpu_rdata",  cpu_if.rdata, 32'h0);
        chk("rst_dbg_rdata",  dbg_if.rdata, 32'h0);
        chk("rst_ram_addr",   ram_addr1, 9'h0);
        chk("rst_ram_wdata",  ram_wdata1, 32'h0);
        chk("rst_ram_wren",   ram_wren1, 1'b0);
        chk("rst_state",      u_dut.r_state, IDLE);
        chk("rst_last_grant", u_dut.u_arb.r_last_grant, GNT_DBG);
        step();

        // CPU write then read back; debug preload of another word
        txn(GNT_CPU, 1'b1, 9'h010, 32'hDEAD_BEEF);
        txn(GNT_CPU, 1'b0, 9'h010, 32'h0);
        txn(GNT_DBG, 1'b1, 9'h020, 32'h0BAD_F00D);

        // Tie right after reset: CPU first, then DBG
        do_reset();
        c = cyc;
        push_exp(GNT_CPU, 1'b0, 9'h040, 32'h0, c + 3);
        push_exp(GNT_DBG, 1'b0, 9'h020, 32'h0, c + 7);
        drive(GNT_CPU, 1'b0, 9'h040, 32'h0);
        drive(GNT_DBG, 1'b0, 9'h020, 32'h0);
        fork
            begin wait_ack(GNT_CPU, w1); step(); drop(GNT_CPU); end
            begin wait_ack(GNT_DBG, w2); step(); drop(GNT_DBG); end
        join

        // Continuous contention: strict alternation, one IDLE between
        c = cyc;
        for (int i = 0; i < 6; i++) begin
            push_exp((i % 2 == 1) ? GNT_DBG : GNT_CPU, 1'b0,
                     (i % 2 == 1) ? 9'h060 : 9'h050, 32'h0, c + 3 + 4 * i);
        end
        drive(GNT_CPU, 1'b0, 9'h050, 32'h0);
        drive(GNT_DBG, 1'b0, 9'h060, 32'h0);
        fork
            begin for (int i = 0; i < 3; i++) wait_ack(GNT_CPU, w1); step(); drop(GNT_CPU); end
            begin for (int j = 0; j < 3; j++) wait_ack(GNT_DBG, w2); step(); drop(GNT_DBG); end
        join

        // Address changed during WAIT must not affect the read
        c = cyc;
        push_exp(GNT_DBG, 1'b0, 9'h020, 32'h0, c + 3);
        drive(GNT_DBG, 1'b0, 9'h020, 32'h0);
        step();
        step();
        dbg_if.addr = 9'h030;
        @(negedge clk);
        chk("ram_addr_held_in_wait", ram_addr1, 9'h020);
        wait_ack(GNT_DBG, w2);
        step();
        drop(GNT_DBG);

        // Reset in the ISSUE cycle of a write: outputs clear at once, write lost
        drive(GNT_CPU, 1'b1, 9'h070, 32'h1234_5678);
        step();
        @(negedge clk);
        chk("wren_in_issue", ram_wren1, 1'b1);
        #1;
        reset_n    = 1'b0;
        cpu_if.req = 1'b0;
        #1;
        chk("async_rst_wren",      ram_wren1, 1'b0);
        chk("async_rst_ram_addr",  ram_addr1, 9'h0);
        chk("async_rst_ram_wdata", ram_wdata1, 32'h0);
        chk("async_rst_cpu_rdata", cpu_if.rdata, 32'h0);
        chk("async_rst_dbg_rdata", dbg_if.rdata, 32'h0);
        model_cpu_rd = '0;
        model_dbg_rd = '0;
        step();
        step();
        reset_n = 1'b1;
        step();
        txn(GNT_CPU, 1'b0, 9'h070, 32'h0);

        // READ_LAT=3 instance: write, then read with ack five cycles after issue
        c = cyc;
        cpu3_if.req = 1'b1; cpu3_if.wr = 1'b1; cpu3_if.addr = 9'h011; cpu3_if.wdata = 32'hCAFE_F00D;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lat3_wr_wren", ram_wren3, cyc == c + 1);
            chk("lat3_wr_ack",  cpu3_if.ack, cyc == c + 2);
        end
        step();
        cpu3_if.req = 1'b0;
        c = cyc;
        cpu3_if.req = 1'b1; cpu3_if.wr = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("lat3_rd_ack", cpu3_if.ack, cyc == c + 5);
            if (cyc >= c + 1 && cyc <= c + 5) chk("lat3_ram_addr", ram_addr3, 9'h011);
            if (cyc == c + 5) chk("lat3_rdata", cpu3_if.rdata, 32'hCAFE_F00D);
        end
        cpu3_if.req = 1'b0;

        // Drain the scoreboard
        for (int n = 0; n < 50 && sbq.size() != 0; n++) @(negedge clk);
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d expected acks never seen", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
